// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// immediate format selectors, pipeline occupancy states and the XLEN check.
package imm_pkg;

  // Immediate format selectors carried on in_imm_src; 110 and 111 are reserved.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  // Occupancy of the stage: nothing held, output register full, output plus skid full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  // Only RV32 and RV64 result widths are supported.
  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_stage_gen.sv
// Purely combinational immediate extractor: picks the fields of instr[31:7]
// for the selected format and sign- or zero-extends them to XLEN bits.
module imm_gen_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic s;
  assign s = instr[31];

  // Format decode; reserved selectors give a zero immediate and raise illegal.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: imm = {{(XLEN-12){s}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      // LUI semantics: bit 31 of the 32-bit result is replicated on RV64.
      IMM_U: imm = {{(XLEN-31){s}}, instr[30:12], 12'b0};
      IMM_Z: imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-stage immediate generator with valid/ready handshake and a two-entry
// skid buffer (output register + skid register). in_ready comes straight from
// the state register, so it never depends combinationally on out_ready.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  // Opcode bits carry no immediate information.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  state_t state_reg;
  state_t state_next;

  logic [XLEN-1:0]  gen_imm;
  logic             gen_illegal;

  logic [XLEN-1:0]  out_imm_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             out_illegal_reg;
  logic [XLEN-1:0]  skid_imm_reg;
  logic [TAG_W-1:0] skid_tag_reg;
  logic             skid_illegal_reg;

  logic accept;
  logic pop;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;

  imm_gen_comb #(.XLEN(XLEN)) u_gen (
    .instr   (in_instr[31:7]),
    .imm_src (in_imm_src),
    .imm     (gen_imm),
    .illegal (gen_illegal)
  );

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_EMPTY;
    else     state_reg <= state_next;
  end

  // Next-state: flush empties the stage regardless of any same-cycle transfer.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state_next = ST_TWO;
          else if (pop && !accept) state_next = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs and datapath load enables derived from the current state.
  always_comb begin
    in_ready           = (state_reg != ST_TWO);
    out_valid          = (state_reg != ST_EMPTY);
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    if (!flush) begin
      case (state_reg)
        ST_EMPTY: load_out_from_in = accept;
        ST_ONE: begin
          load_out_from_in = accept && pop;
          load_skid        = accept && !pop;
        end
        ST_TWO:   load_out_from_skid = pop;
        default: ;
      endcase
    end
  end

  // Output and skid registers move only on accept/pop; they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_imm_reg      <= '0;
      out_tag_reg      <= '0;
      out_illegal_reg  <= 1'b0;
      skid_imm_reg     <= '0;
      skid_tag_reg     <= '0;
      skid_illegal_reg <= 1'b0;
    end else begin
      if (load_out_from_in) begin
        out_imm_reg     <= gen_imm;
        out_tag_reg     <= in_tag;
        out_illegal_reg <= gen_illegal;
      end else if (load_out_from_skid) begin
        out_imm_reg     <= skid_imm_reg;
        out_tag_reg     <= skid_tag_reg;
        out_illegal_reg <= skid_illegal_reg;
      end
      if (load_skid) begin
        skid_imm_reg     <= gen_imm;
        skid_tag_reg     <= in_tag;
        skid_illegal_reg <= gen_illegal;
      end
    end
  end

  assign out_imm     = out_imm_reg;
  assign out_tag     = out_tag_reg;
  assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: an RV64 and an RV32 instance share
// all inputs and are checked against an arithmetic reference model.
module tb_imm_decode_stage;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0] in_imm_src = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [TAG_W-1:0] out_tag64;
  logic in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [TAG_W-1:0] out_tag32;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [TAG_W-1:0] tag;
    logic ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  imm_decode_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: immediate value as a plain signed integer built from weighted fields.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    longint v;
    longint sgn;
    sgn = ins[31] ? 64'sd1 : 64'sd0;
    v = 0;
    e.ill = 1'b0;
    case (src)
      3'd0: v = longint'(ins[31:20]) - sgn * 4096;
      3'd1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - sgn * 4096;
      3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                + longint'(ins[11:8]) * 2 - sgn * 4096;
      3'd3: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                + longint'(ins[30:21]) * 2 - sgn * 1048576;
      3'd4: v = longint'(ins[31:12]) * 4096 - sgn * 64'sd4294967296;
      3'd5: v = longint'(ins[19:15]);
      default: begin v = 0; e.ill = 1'b1; end
    endcase
    e.imm64 = v;
    e.imm32 = v[31:0];
    e.tag = tag;
    return e;
  endfunction

  // One cycle of stimulus; pushes the expected result if the item is accepted.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [TAG_W-1:0] tg, input exp_t e, input logic fl,
                       input logic ordy, output logic acc);
    in_valid = v; in_instr = ins; in_imm_src = src; in_tag = tg;
    flush = fl; out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready64 && !fl;
    if (fl) sb.delete();
    else if (acc) begin
      sb.push_back(e);
      $display("tb: accept tag=%0d src=%0d instr=0x%08h", tg, src, ins);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input logic ordy, input int n);
    exp_t e;
    logic acc;
    e = model(32'h0, 3'd0, '0);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 3'd0, '0, e, 1'b0, ordy, acc);
  endtask

  task automatic send_exp(input logic [31:0] ins, input logic [2:0] src,
                          input logic [TAG_W-1:0] tg, input logic [63:0] x64,
                          input logic [31:0] x32, input logic ill, input logic ordy);
    exp_t e;
    logic acc;
    e.imm64 = x64; e.imm32 = x32; e.tag = tg; e.ill = ill;
    drive(1'b1, ins, src, tg, e, 1'b0, ordy, acc);
    if (!acc) chk("send_accept", {63'd0, acc}, 64'd1);
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && out_valid64 && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output_tag", {59'd0, out_tag64}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        $display("tb: emit tag=%0d imm64=0x%016h imm32=0x%08h ill=%0d",
                 out_tag64, out_imm64, out_imm32, out_illegal64);
        chk("imm64", out_imm64, e.imm64);
        chk("imm32", {32'd0, out_imm32}, {32'd0, e.imm32});
        chk("tag64", {59'd0, out_tag64}, {59'd0, e.tag});
        chk("tag32", {59'd0, out_tag32}, {59'd0, e.tag});
        chk("illegal64", {63'd0, out_illegal64}, {63'd0, e.ill});
        chk("valid32", {63'd0, out_valid32}, 64'd1);
      end
    end
  end

  initial begin
    exp_t e;
    logic acc;
    logic [31:0] r_ins;
    logic [2:0] r_src;
    logic [TAG_W-1:0] r_tag;
    int tries;

    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", {63'd0, out_valid64}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready64}, 64'd1);
    chk("rst_out_imm", out_imm64, 64'd0);
    rst = 1'b0;

    // Known encodings, one at a time with out_ready high
    send_exp(32'hFFF00093, 3'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("latency_out_valid", {63'd0, out_valid64}, 64'd1);
    send_exp(32'hFE000EE3, 3'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b1);
    send_exp(32'h0080006F, 3'd3, 5'd3, 64'd8, 32'd8, 1'b0, 1'b1);
    send_exp(32'h000F8000, 3'd5, 5'd4, 64'h1F, 32'h1F, 1'b0, 1'b1);
    send_exp(32'h800000B7, 3'd4, 5'd5, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    send_exp(32'hFE112E23, 3'd1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b1);
    send_exp(32'hFFFFFFFF, 3'd7, 5'd7, 64'd0, 32'd0, 1'b1, 1'b1);
    send_exp(32'h12345678, 3'd6, 5'd8, 64'd0, 32'd0, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Backpressure: tags 1,2,3 with out_ready low; third must be held upstream
    e = model(32'h00100013, 3'd0, 5'd1);
    drive(1'b1, 32'h00100013, 3'd0, 5'd1, e, 1'b0, 1'b0, acc);
    e = model(32'h00200013, 3'd0, 5'd2);
    drive(1'b1, 32'h00200013, 3'd0, 5'd2, e, 1'b0, 1'b0, acc);
    chk("full_in_ready", {63'd0, in_ready64}, 64'd0);
    e = model(32'h00300013, 3'd0, 5'd3);
    drive(1'b1, 32'h00300013, 3'd0, 5'd3, e, 1'b0, 1'b0, acc);
    chk("held_not_accepted", {63'd0, acc}, 64'd0);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 10) begin
      drive(1'b1, 32'h00300013, 3'd0, 5'd3, e, 1'b0, 1'b1, acc);
      tries++;
    end
    chk("tag3_eventually_accepted", {63'd0, acc}, 64'd1);
    idle(1'b1, 4);
    chk("drained_after_bp", 64'(sb.size()), 64'd0);

    // Flush in TWO with a same-cycle input offered
    e = model(32'hABC00013, 3'd0, 5'd11);
    drive(1'b1, 32'hABC00013, 3'd0, 5'd11, e, 1'b0, 1'b0, acc);
    e = model(32'hDEF00013, 3'd0, 5'd12);
    drive(1'b1, 32'hDEF00013, 3'd0, 5'd12, e, 1'b0, 1'b0, acc);
    e = model(32'h11100013, 3'd0, 5'd13);
    drive(1'b1, 32'h11100013, 3'd0, 5'd13, e, 1'b1, 1'b0, acc);
    chk("flush_out_valid", {63'd0, out_valid64}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready64}, 64'd1);
    idle(1'b1, 3);
    chk("flush_nothing_emitted", {63'd0, out_valid64}, 64'd0);

    // Reset while in TWO
    e = model(32'hFFF00093, 3'd0, 5'd9);
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd9, e, 1'b0, 1'b0, acc);
    e = model(32'h0, 3'd7, 5'd10);
    drive(1'b1, 32'h0, 3'd7, 5'd10, e, 1'b0, 1'b0, acc);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_out_valid", {63'd0, out_valid64}, 64'd0);
    chk("rst2_out_imm", out_imm64, 64'd0);
    chk("rst2_out_tag", {59'd0, out_tag64}, 64'd0);
    chk("rst2_out_illegal", {63'd0, out_illegal64}, 64'd0);
    chk("rst2_in_ready", {63'd0, in_ready64}, 64'd1);
    idle(1'b1, 2);

    // Randomised traffic with random backpressure and occasional flush
    r_ins = $urandom; r_src = 3'($urandom_range(0, 7)); r_tag = TAG_W'($urandom);
    for (int n = 0; n < 400; n++) begin
      logic v, fl, ordy;
      v = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      e = model(r_ins, r_src, r_tag);
      drive(v, r_ins, r_src, r_tag, e, fl, ordy, acc);
      if (acc || (v && fl)) begin
        r_ins = $urandom; r_src = 3'($urandom_range(0, 7)); r_tag = TAG_W'($urandom);
      end
    end
    idle(1'b1, 5);
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
